// File: rtl/issue_sched_pkg.sv
// Shared widths, decode-word field offsets and entry/lane types for the issue scheduler.
package issue_sched_pkg;

   localparam int unsigned PC_W     = 32;
   localparam int unsigned DEC_W    = 16;
   localparam int unsigned QDEPTH   = 4;
   localparam int unsigned PTR_W    = 2;
   localparam int unsigned CNT_W    = 3;
   localparam int unsigned REG_W    = 5;

   // Decode word layout: {rfwe, rd, rt, rs}
   localparam int unsigned RS_LSB   = 0;
   localparam int unsigned RT_LSB   = 5;
   localparam int unsigned RD_LSB   = 10;
   localparam int unsigned RFWE_BIT = 15;

   localparam logic [DEC_W-1:0] DEC_NOP    = '0;
   localparam logic [PC_W-1:0]  BUBBLE_NPC = 32'd4;

   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic [PC_W-1:0]  npc;
      logic [DEC_W-1:0] dec;
   } entry_t;

   typedef struct packed {
      logic   valid;
      entry_t e;
   } lane_t;

   localparam entry_t ENTRY_BUBBLE = '{pc: '0, npc: BUBBLE_NPC, dec: DEC_NOP};
   localparam lane_t  LANE_BUBBLE  = '{valid: 1'b0, e: ENTRY_BUBBLE};

   function automatic logic raw_hazard(input logic [DEC_W-1:0] older,
                                       input logic [DEC_W-1:0] younger);
      logic [REG_W-1:0] rd;
      rd = older[RD_LSB +: REG_W];
      return older[RFWE_BIT] && (rd != '0) &&
             ((rd == younger[RS_LSB +: REG_W]) || (rd == younger[RT_LSB +: REG_W]));
   endfunction

endpackage

// File: rtl/issue_sched_if.sv
// Enqueue, dispatch and branch-feedback signals of the issue scheduler.
interface issue_sched_if;
   import issue_sched_pkg::*;

   logic [1:0]       in_valid;
   logic [PC_W-1:0]  in_pc0, in_pc1, in_npc0, in_npc1;
   logic [DEC_W-1:0] in_dec0, in_dec1;
   logic             stop;
   logic             br_flag0, br_flag1;
   logic [PC_W-1:0]  br_addr0, br_addr1;

   logic             in_ready;
   logic             d0_valid, d1_valid, d0_num, d1_num;
   logic [PC_W-1:0]  d0_pc, d1_pc, d0_npc, d1_npc;
   logic [DEC_W-1:0] d0_dec, d1_dec;
   logic             kill1;
   logic             redirect_valid;
   logic [PC_W-1:0]  redirect_pc;

   modport master (
      output in_valid, in_pc0, in_pc1, in_npc0, in_npc1, in_dec0, in_dec1, stop,
             br_flag0, br_flag1, br_addr0, br_addr1,
      input  in_ready, d0_valid, d1_valid, d0_num, d1_num, d0_pc, d1_pc,
             d0_npc, d1_npc, d0_dec, d1_dec, kill1, redirect_valid, redirect_pc
   );

   modport slave (
      input  in_valid, in_pc0, in_pc1, in_npc0, in_npc1, in_dec0, in_dec1, stop,
             br_flag0, br_flag1, br_addr0, br_addr1,
      output in_ready, d0_valid, d1_valid, d0_num, d1_num, d0_pc, d1_pc,
             d0_npc, d1_npc, d0_dec, d1_dec, kill1, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/issue_queue.sv
// 4-entry circular FIFO: up to two pushes at tail, two peeks at head, pop 0/1/2, flush.
module issue_queue
   import issue_sched_pkg::*;
(
   input  logic             clk,
   input  logic             rst_s1,
   input  logic [1:0]       push,
   input  entry_t           push0,
   input  entry_t           push1,
   input  logic [1:0]       pop,
   input  logic             flush,
   output entry_t           peek0,
   output entry_t           peek1,
   output logic [CNT_W-1:0] count
);

   entry_t             mem_q [QDEPTH];
   entry_t             mem_d [QDEPTH];
   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q + pop;
      tail_d  = tail_q + push;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (push != 2'd0) mem_d[tail_q] = push0;
      if (push == 2'd2) mem_d[tail_q + 2'd1] = push1;
      if (flush) begin
         // Empty by advancing head onto tail; writes that cycle are discarded.
         mem_d   = mem_q;
         head_d  = tail_q;
         tail_d  = tail_q;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_s1) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < QDEPTH; i++) mem_q[i] <= mem_d[i];
   end

   assign peek0 = mem_q[head_q];
   assign peek1 = mem_q[head_q + 2'd1];
   assign count = count_q;

endmodule

// File: rtl/issue_sched.sv
// Dual-lane in-order issue: enqueue into issue_queue, RAW-checked pair dispatch, branch redirect.
module issue_sched
   import issue_sched_pkg::*;
(
   input  logic         clk,
   input  logic         rst_s1,
   issue_sched_if.slave bus
);

   logic [CNT_W-1:0] count;
   entry_t           peek0, peek1, push0, push1;
   logic [1:0]       push, pop;
   logic             redirect, kill1, in_ready, iss0, iss1;
   logic [PC_W-1:0]  redirect_pc;
   lane_t            lane0_q, lane0_d, lane1_q, lane1_d;

   always_comb begin
      redirect    = 1'b0;
      redirect_pc = '0;
      kill1       = 1'b0;
      if (rst_s1 && !bus.stop) begin
         if (lane0_q.valid && bus.br_flag0) begin
            redirect    = 1'b1;
            redirect_pc = bus.br_addr0;
            kill1       = lane1_q.valid;
         end else if (lane1_q.valid && bus.br_flag1) begin
            redirect    = 1'b1;
            redirect_pc = bus.br_addr1;
         end
      end
   end

   assign in_ready = (count <= CNT_W'(2)) && !redirect;

   always_comb begin
      push  = 2'd0;
      push0 = '{pc: bus.in_pc0, npc: bus.in_npc0, dec: bus.in_dec0};
      push1 = '{pc: bus.in_pc1, npc: bus.in_npc1, dec: bus.in_dec1};
      if (in_ready) begin
         case (bus.in_valid)
            2'b11:   push = 2'd2;
            2'b01:   push = 2'd1;
            2'b10: begin
               push  = 2'd1;
               push0 = push1;
            end
            default: push = 2'd0;
         endcase
      end
   end

   always_comb begin
      iss0    = !bus.stop && !redirect && (count != '0);
      iss1    = iss0 && (count >= CNT_W'(2)) && !raw_hazard(peek0.dec, peek1.dec);
      pop     = {1'b0, iss0} + {1'b0, iss1};
      lane0_d = lane0_q;
      lane1_d = lane1_q;
      if (!bus.stop) begin
         lane0_d = iss0 ? '{valid: 1'b1, e: peek0} : LANE_BUBBLE;
         lane1_d = iss1 ? '{valid: 1'b1, e: peek1} : LANE_BUBBLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_s1) begin
         lane0_q <= LANE_BUBBLE;
         lane1_q <= LANE_BUBBLE;
      end else begin
         lane0_q <= lane0_d;
         lane1_q <= lane1_d;
      end
   end

   issue_queue u_queue (
      .clk    (clk),
      .rst_s1 (rst_s1),
      .push   (push),
      .push0  (push0),
      .push1  (push1),
      .pop    (pop),
      .flush  (redirect),
      .peek0  (peek0),
      .peek1  (peek1),
      .count  (count)
   );

   assign bus.in_ready       = in_ready;
   assign bus.redirect_valid = redirect;
   assign bus.redirect_pc    = redirect_pc;
   assign bus.kill1          = kill1;
   assign bus.d0_num         = 1'b0;
   assign bus.d1_num         = 1'b1;
   assign bus.d0_valid       = lane0_q.valid;
   assign bus.d0_pc          = lane0_q.e.pc;
   assign bus.d0_npc         = lane0_q.e.npc;
   assign bus.d0_dec         = lane0_q.e.dec;
   assign bus.d1_valid       = lane1_q.valid;
   assign bus.d1_pc          = lane1_q.e.pc;
   assign bus.d1_npc         = lane1_q.e.npc;
   assign bus.d1_dec         = lane1_q.e.dec;

endmodule
